// File: rtl/mult_hilo_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_hilo_unit_pkg
//
// Shared definitions for the HI/LO multiply unit:
//   WIDTH      - operand width. Only 32 works, because umultiplier is a fixed
//                32x32->64 array.
//   HILO_RESET - value that HI and LO take on reset.
//   state_t    - sequencing FSM states (IDLE -> MUL -> WB).
//   magnitude  - absolute value of a two's-complement operand. It returns the
//                raw value when the operation is unsigned.
// -----------------------------------------------------------------------------
package mult_hilo_unit_pkg;

    localparam int              WIDTH      = 32;
    localparam logic [31:0]     HILO_RESET = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    // 32'h80000000 maps to itself. That is the correct magnitude once the
    // result is treated as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return (~v) + WIDTH'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mult_hilo_unit_umultiplier.sv
// -----------------------------------------------------------------------------
// umultiplier
//
// Combinational 32x32 -> 64 unsigned multiplier. The sequencing stage around
// this block registers its inputs and captures its output, so the block has
// no internal state.
//
// Ports:
//   a       in  32  unsigned multiplicand
//   b       in  32  unsigned multiplier
//   product out 64  a * b (cannot overflow)
// -----------------------------------------------------------------------------
module umultiplier
    import mult_hilo_unit_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    // Widen both operands before the multiply so that the full 64-bit
    // product is kept rather than the truncated 32-bit context result.
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    assign a_ext   = {{WIDTH{1'b0}}, a};
    assign b_ext   = {{WIDTH{1'b0}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/mult_hilo_unit.sv
// -----------------------------------------------------------------------------
// mult_hilo_unit
//
// Sequential front-end and result stage around umultiplier. It implements
// MULT/MULTU into the architectural HI/LO pair and services MTHI/MTLO.
//
// Flow: IDLE latches the operand magnitudes and the result sign. MUL registers
// the unsigned product. WB writes HI/LO, negating the product when needed, and
// pulses done. A multiply therefore occupies three cycles. The next request is
// accepted in the same cycle that done is high.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   start      in   1   multiply request (sampled only in IDLE)
//   signed_op  in   1   1 = MULT (signed), 0 = MULTU
//   rs_val     in   32  multiplicand
//   rt_val     in   32  multiplier
//   mthi       in   1   write wr_data to HI (IDLE only, start has priority)
//   mtlo       in   1   write wr_data to LO (IDLE only, start has priority)
//   wr_data    in   32  MTHI/MTLO data
//   busy       out  1   multiply in flight (state != IDLE)
//   done       out  1   one-cycle pulse: HI/LO hold a new product
//   hi         out  32  HI register
//   lo         out  32  LO register
// -----------------------------------------------------------------------------
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int          WIDTH      = mult_hilo_unit_pkg::WIDTH,
    parameter logic [31:0] HILO_RESET = mult_hilo_unit_pkg::HILO_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mult_out;
    logic [2*WIDTH-1:0] result;

    // ------------------------------------------------------------------
    // Multiplier array. It is fed from registered magnitudes, so the
    // array sees stable inputs for the whole MUL cycle.
    // ------------------------------------------------------------------
    umultiplier u_umultiplier (
        .a       (a_mag),
        .b       (b_mag),
        .product (mult_out)
    );

    // Sign correction is a full 64-bit two's-complement negate. A zero
    // product negates to zero, so a zero product stays zero.
    assign result = neg ? ((~prod) + (2*WIDTH)'(1)) : prod;

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment, so every flop
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nxt is given a default before the case statement, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    // NOTE: the operand, product and HI/LO registers are all reset along
    // with the FSM. A reset in mid-operation then leaves no stale product
    // that a later WB could expose.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mag <= '0;
            b_mag <= '0;
            neg   <= 1'b0;
            prod  <= '0;
            hi    <= HILO_RESET[WIDTH-1:0];
            lo    <= HILO_RESET[WIDTH-1:0];
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // start takes priority: a move that arrives together
                    // with a multiply request is dropped.
                    if (start) begin
                        a_mag <= magnitude(rs_val, signed_op);
                        b_mag <= magnitude(rt_val, signed_op);
                        neg   <= signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    end else begin
                        if (mthi) hi <= wr_data;
                        if (mtlo) lo <= wr_data;
                    end
                end
                MUL: begin
                    prod <= mult_out;
                end
                WB: begin
                    hi   <= result[2*WIDTH-1:WIDTH];
                    lo   <= result[WIDTH-1:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_hilo_unit
//
// Bench for mult_hilo_unit. Inputs are driven and outputs are sampled on the
// falling clock edge. Each multiply pushes its expected {hi,lo} into a
// scoreboard queue. The entry is popped when done is seen. Expected products
// come from native 64-bit signed/unsigned multiplication.
// -----------------------------------------------------------------------------
module tb_mult_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passed = 0;

    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mult_hilo_unit #(
        .WIDTH      (32),
        .HILO_RESET (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Reference product, computed with native arithmetic.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] r;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            r  = sa * sb;
        end else begin
            r = {32'h0, a} * {32'h0, b};
        end
        return r;
    endfunction

    // Drive a request at the current falling edge and record its expectation.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        signed_op = s;
        rs_val    = a;
        rt_val    = b;
        sb_q.push_back(model(s, a, b));
    endtask

    // Follow one request to its done pulse. Checks busy during the two
    // in-flight cycles, checks the latency, then compares against the
    // scoreboard. Returns at the falling edge of the done cycle.
    task automatic wait_result(input string name);
        logic [63:0] exp;
        bit          seen = 1'b0;
        int          lat  = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end else if (i <= 2) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL %s busy cycle %0d: got %b want 1", name, i, busy);
                else passed++;
            end
        end
        checks++;
        if (!seen) begin
            $display("FAIL %s timeout: no done within 8 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        passed++;
        checks++;
        if (lat != 3) $display("FAIL %s latency: got %0d want 3", name, lat);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy at done: got %b want 0", name, busy);
        else passed++;
        checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s scoreboard: unexpected done", name);
            return;
        end
        passed++;
        exp = sb_q.pop_front();
        checks++;
        if (hi !== exp[63:32]) $display("FAIL %s hi: got %h want %h", name, hi, exp[63:32]);
        else passed++;
        checks++;
        if (lo !== exp[31:0]) $display("FAIL %s lo: got %h want %h", name, lo, exp[31:0]);
        else passed++;
    endtask

    // done must stay low, with the unit idle, for n cycles.
    task automatic expect_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL %s quiet cycle %0d: done=%b busy=%b want 0/0", name, i, done, busy);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL reset state: busy=%b done=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo);
        else passed++;
        reset = 1'b0;
        expect_quiet("post_reset", 2);
    endtask

    task automatic test_multu_max();
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_result("multu_max");
        expect_quiet("multu_max_tail", 1);
    endtask

    task automatic test_signed();
        issue(1'b1, 32'hFFFFFFFD, 32'h00000005);
        wait_result("mult_neg3x5");
        issue(1'b0, 32'hFFFFFFFD, 32'h00000005);
        wait_result("multu_neg3x5");
        issue(1'b1, 32'h00000007, 32'hFFFFFFF9);
        wait_result("mult_7xneg7");
        issue(1'b1, 32'hFFFFFFFB, 32'hFFFFFFF8);
        wait_result("mult_negxneg");
        expect_quiet("signed_tail", 1);
    endtask

    task automatic test_min_int();
        issue(1'b1, 32'h80000000, 32'h80000000);
        wait_result("mult_min_sq");
        issue(1'b1, 32'h80000000, 32'h00000001);
        wait_result("mult_min_x1");
        issue(1'b1, 32'hFFFFFFFB, 32'h00000000);
        wait_result("mult_neg_zero");
        expect_quiet("min_int_tail", 1);
    endtask

    // Each new request is driven in the done cycle of the previous one.
    task automatic test_back_to_back();
        issue(1'b0, 32'h00010001, 32'h00010001);
        wait_result("b2b_0");
        for (int k = 1; k <= 3; k++) begin
            issue(k[0], $urandom(), $urandom());
            wait_result($sformatf("b2b_%0d", k));
        end
        expect_quiet("b2b_tail", 1);
    endtask

    task automatic test_busy_ignore();
        issue(1'b0, 32'd2, 32'd3);
        @(negedge clk);             // cycle t+1
        checks++;
        if (busy !== 1'b1) $display("FAIL ignore busy t+1: got %b want 1", busy);
        else passed++;
        start = 1'b1; rs_val = 32'd7; rt_val = 32'd7; mthi = 1'b1; wr_data = 32'hDEAD;
        @(negedge clk);             // cycle t+2
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL ignore busy t+2: got %b want 1", busy);
        else passed++;
        @(negedge clk);             // cycle t+3
        checks++;
        if (done !== 1'b1) $display("FAIL ignore done t+3: got %b want 1", done);
        else passed++;
        void'(sb_q.pop_front());
        checks++;
        if (hi !== 32'h0 || lo !== 32'd6)
            $display("FAIL ignore result: got %h_%h want 00000000_00000006", hi, lo);
        else passed++;
        expect_quiet("ignore_tail", 4);
    endtask

    task automatic test_moves();
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h12345678 || done !== 1'b0)
            $display("FAIL move both: got hi=%h lo=%h done=%b want 12345678/12345678/0", hi, lo, done);
        else passed++;
        mthi = 1'b1; wr_data = 32'hAAAA5555;
        @(negedge clk);
        mthi = 1'b0;
        checks++;
        if (hi !== 32'hAAAA5555 || lo !== 32'h12345678)
            $display("FAIL move hi: got hi=%h lo=%h want aaaa5555/12345678", hi, lo);
        else passed++;
        mtlo = 1'b1; wr_data = 32'h0F0F0F0F;
        @(negedge clk);
        mtlo = 1'b0;
        checks++;
        if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F)
            $display("FAIL move lo: got hi=%h lo=%h want aaaa5555/0f0f0f0f", hi, lo);
        else passed++;
        // start together with both moves: the multiply wins.
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hDEADBEEF;
        issue(1'b0, 32'd3, 32'd4);
        wait_result("move_vs_start");
        expect_quiet("moves_tail", 1);
    endtask

    task automatic test_reset_abort();
        issue(1'b0, 32'd5, 32'd5);
        @(negedge clk);             // cycle t+1
        start = 1'b0;
        @(negedge clk);             // cycle t+2
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL abort async: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        else passed++;
        void'(sb_q.pop_front());
        @(negedge clk);
        reset = 1'b0;
        expect_quiet("abort_tail", 4);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL abort hilo: got %h_%h want 0_0", hi, lo);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_min_int();
        test_back_to_back();
        test_busy_ignore();
        test_moves();
        test_reset_abort();
        checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard leftover: got %0d want 0", sb_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
